// File: rtl/ctrl_pkg.sv
// Shared types for the control_module transmit path: arbiter FSM states and
// the payload-to-byte-count helper.
package ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  function automatic int unsigned max_bytes(input int unsigned word_size,
                                            input int unsigned data_width);
    return word_size / data_width;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first asserted request at or after
// ptr_i (wrapping) wins; outputs a one-hot grant and its index.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic             found;
  logic [IDX_W-1:0] pos;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    pos     = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      pos = IDX_W'((32'(ptr_i) + off) % NUM_REQ);
      if (!found && req_i[pos]) begin
        found        = 1'b1;
        grant_o[pos] = 1'b1;
        idx_o        = pos;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of the status_sender_data transmit path between NUM_REQ
// requesters. Optional frame watchdog: define UART_TX_ARB_WATCHDOG_EN.
module uart_tx_arbiter
  import ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned WORD_SIZE  = 32,
  parameter int unsigned SIZE_WORD  = 3,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TIMEOUT_W  = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*WORD_SIZE-1:0]   req_data,
  input  logic [NUM_REQ*SIZE_WORD-1:0]   req_size,
  output logic [NUM_REQ-1:0]             req_ack,
  input  logic                           busy,
  output logic                           valid_data,
  output logic [WORD_SIZE-1:0]           data_to_send,
  output logic [SIZE_WORD-1:0]           size_of_data,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id,
  output logic                           arb_busy,
  output logic                           timeout_err
);

  localparam int unsigned          IDX_W    = $clog2(NUM_REQ);
  localparam logic [SIZE_WORD-1:0] MAX_SIZE = SIZE_WORD'(max_bytes(WORD_SIZE, DATA_WIDTH));

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("uart_tx_arbiter: NUM_REQ must be in 2..8");
  end
  if (TIMEOUT_W < 2) begin : g_bad_timeout_w
    $error("uart_tx_arbiter: TIMEOUT_W must be at least 2");
  end

  state_t                 state_q;
  logic [IDX_W-1:0]       rr_ptr_q;
  logic [NUM_REQ-1:0]     req_ack_q;
  logic                   valid_q;
  logic [WORD_SIZE-1:0]   data_q;
  logic [SIZE_WORD-1:0]   size_q;
  logic [IDX_W-1:0]       grant_q;

  logic [NUM_REQ-1:0]     gnt_oh;
  logic [IDX_W-1:0]       gnt_idx;
  logic [WORD_SIZE-1:0]   data_arr [NUM_REQ];
  logic [SIZE_WORD-1:0]   size_arr [NUM_REQ];
  logic [WORD_SIZE-1:0]   sel_data;
  logic [SIZE_WORD-1:0]   sel_size;
  logic [SIZE_WORD-1:0]   size_d;
  logic [IDX_W-1:0]       rr_ptr_d;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (gnt_oh),
    .idx_o   (gnt_idx)
  );

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign data_arr[gi] = req_data[gi*WORD_SIZE +: WORD_SIZE];
    assign size_arr[gi] = req_size[gi*SIZE_WORD +: SIZE_WORD];
  end

  always_comb begin
    sel_data = data_arr[gnt_idx];
    sel_size = size_arr[gnt_idx];
    size_d   = (sel_size > MAX_SIZE) ? MAX_SIZE : sel_size;
    rr_ptr_d = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  end

`ifdef UART_TX_ARB_WATCHDOG_EN
  localparam logic [TIMEOUT_W-1:0] WD_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
  logic [TIMEOUT_W-1:0] wd_q;
  logic                 timeout_q;
`endif

  // Watchdog fires on the edge where the count would reach all-ones, so the
  // pulse appears (2**TIMEOUT_W - 1) cycles after entering a wait state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      req_ack_q <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      size_q    <= '0;
      grant_q   <= '0;
`ifdef UART_TX_ARB_WATCHDOG_EN
      wd_q      <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      req_ack_q <= '0;
      valid_q   <= 1'b0;
`ifdef UART_TX_ARB_WATCHDOG_EN
      timeout_q <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
`ifdef UART_TX_ARB_WATCHDOG_EN
          wd_q <= '0;
`endif
          if (!busy && (|req_valid)) begin
            req_ack_q <= gnt_oh;
            rr_ptr_q  <= rr_ptr_d;
            if (sel_size != '0) begin
              data_q  <= sel_data;
              size_q  <= size_d;
              grant_q <= gnt_idx;
              valid_q <= 1'b1;
              state_q <= WAIT_BUSY;
            end
          end
        end
        WAIT_BUSY: begin
          if (busy) begin
            state_q <= WAIT_DONE;
`ifdef UART_TX_ARB_WATCHDOG_EN
            wd_q    <= '0;
          end else if (wd_q == WD_LAST) begin
            timeout_q <= 1'b1;
            state_q   <= IDLE;
          end else begin
            wd_q <= wd_q + 1'b1;
`endif
          end
        end
        WAIT_DONE: begin
          if (!busy) begin
            state_q <= IDLE;
`ifdef UART_TX_ARB_WATCHDOG_EN
          end else if (wd_q == WD_LAST) begin
            timeout_q <= 1'b1;
            state_q   <= IDLE;
          end else begin
            wd_q <= wd_q + 1'b1;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ack      = req_ack_q;
  assign valid_data   = valid_q;
  assign data_to_send = data_q;
  assign size_of_data = size_q;
  assign grant_id     = grant_q;
  assign arb_busy     = (state_q != IDLE);
`ifdef UART_TX_ARB_WATCHDOG_EN
  assign timeout_err  = timeout_q;
`else
  assign timeout_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a simple sender model driving busy.
// The watchdog scenario is built only when UART_TX_ARB_WATCHDOG_EN is defined.
module tb_uart_tx_arbiter;

  localparam int FRAME = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [11:0]  req_size;
  logic [3:0]   req_ack;
  logic         busy;
  logic         valid_data;
  logic [31:0]  data_to_send;
  logic [2:0]   size_of_data;
  logic [1:0]   grant_id;
  logic         arb_busy;
  logic         timeout_err;

  logic force_busy = 1'b0;
  logic sender_en  = 1'b1;
  int   sender_cnt;

  typedef struct {
    int          id;
    logic [31:0] data;
    logic [2:0]  size;
    bit          drop;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   tests = 0;
  int   fails = 0;

  uart_tx_arbiter #(
    .NUM_REQ    (4),
    .WORD_SIZE  (32),
    .SIZE_WORD  (3),
    .DATA_WIDTH (8),
    .TIMEOUT_W  (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_size     (req_size),
    .req_ack      (req_ack),
    .busy         (busy),
    .valid_data   (valid_data),
    .data_to_send (data_to_send),
    .size_of_data (size_of_data),
    .grant_id     (grant_id),
    .arb_busy     (arb_busy),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  // Sender: busy rises the cycle after valid_data and stays high FRAME cycles.
  always @(posedge clk or negedge rst) begin
    if (!rst) sender_cnt <= 0;
    else if (valid_data && sender_en) sender_cnt <= FRAME;
    else if (sender_cnt > 0) sender_cnt <= sender_cnt - 1;
  end
  assign busy = force_busy | (sender_cnt != 0);

  task automatic set_req(input int i, input logic [31:0] d, input logic [2:0] s);
    req_data[i*32 +: 32] = d;
    req_size[i*3 +: 3]   = s;
  endtask

  task automatic push(input int id, input logic [31:0] d, input logic [2:0] s, input bit drop);
    exp_t x;
    x.id = id; x.data = d; x.size = s; x.drop = drop;
    sb.push_back(x);
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid = '0; req_data = '0; req_size = '0;
    force_busy = 1'b0; sender_en = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({req_ack, valid_data, arb_busy, timeout_err} !== 7'b0)
      $display("FAIL reset_ctrl: ack=%b valid=%b arb_busy=%b tmo=%b, want all 0",
               req_ack, valid_data, arb_busy, timeout_err);
    tests++;
    if (data_to_send !== 32'h0) begin
      fails++; $display("FAIL reset_data: got %h want 0", data_to_send);
    end
    tests++;
    if ({size_of_data, grant_id} !== 5'b0) begin
      fails++; $display("FAIL reset_size_gid: size=%0d gid=%0d want 0", size_of_data, grant_id);
    end
    if ({req_ack, valid_data, arb_busy, timeout_err} !== 7'b0) fails++;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_rotation();
    int grants = 0;
    int idle_run = 0;
    for (int i = 0; i < 4; i++) set_req(i, 32'hA000_0000 + i, 3'(i + 1));
    for (int k = 0; k < 5; k++)
      push(k % 4, 32'hA000_0000 + (k % 4) + ((k >= 4) ? 32'h100 : 32'h0), 3'((k % 4) + 1), 1'b0);
    req_valid = 4'hF;
    for (int c = 0; c < 300 && grants < 5; c++) begin
      @(negedge clk);
      if (|req_ack) begin
        if (sb.size() == 0) begin
          tests++; fails++; $display("FAIL rot_unexpected_ack: ack=%b", req_ack);
        end else begin
          e = sb.pop_front();
          tests++;
          if (req_ack !== 4'(1 << e.id)) begin
            fails++; $display("FAIL rot_ack%0d: got %b want id %0d", grants, req_ack, e.id);
          end
          tests++;
          if ({valid_data, data_to_send, size_of_data, grant_id} !== {1'b1, e.data, e.size, 2'(e.id)}) begin
            fails++;
            $display("FAIL rot_frame%0d: v=%b d=%h s=%0d g=%0d want v=1 d=%h s=%0d g=%0d",
                     grants, valid_data, data_to_send, size_of_data, grant_id, e.data, e.size, e.id);
          end
          if (grants > 0) begin
            tests++;
            if (idle_run !== 2) begin
              fails++; $display("FAIL rot_gap%0d: %0d idle cycles before ack, want 2", grants, idle_run);
            end
          end
          req_data[e.id*32 +: 32] = req_data[e.id*32 +: 32] + 32'h100;
          grants++;
        end
      end
      idle_run = busy ? 0 : idle_run + 1;
    end
    req_valid = '0;
    tests++;
    if (grants != 5) begin
      fails++; $display("FAIL rot_count: got %0d grants want 5", grants);
    end
    for (int c = 0; c < 100 && arb_busy; c++) @(negedge clk);
    tests++;
    if (arb_busy !== 1'b0 || sb.size() != 0) begin
      fails++; $display("FAIL rot_drain: arb_busy=%b pending=%0d want 0/0", arb_busy, sb.size());
    end
  endtask

  task automatic test_single();
    int c;
    set_req(2, 32'hDEAD_BEEF, 3'd4);
    push(2, 32'hDEAD_BEEF, 3'd4, 1'b0);
    req_valid = 4'b0100;
    @(negedge clk);
    e = sb.pop_front();
    tests++;
    if (req_ack !== 4'b0100 || valid_data !== 1'b1 || arb_busy !== 1'b1) begin
      fails++; $display("FAIL single_pulse: ack=%b v=%b arb_busy=%b want 0100/1/1", req_ack, valid_data, arb_busy);
    end
    tests++;
    if ({data_to_send, size_of_data, grant_id} !== {e.data, e.size, 2'(e.id)}) begin
      fails++; $display("FAIL single_frame: d=%h s=%0d g=%0d want %h/%0d/%0d",
                        data_to_send, size_of_data, grant_id, e.data, e.size, e.id);
    end
    req_valid = '0;
    @(negedge clk);
    tests++;
    if (req_ack !== 4'b0 || valid_data !== 1'b0) begin
      fails++; $display("FAIL single_one_cycle: ack=%b v=%b want 0/0", req_ack, valid_data);
    end
    c = 0;
    while (arb_busy && c < 100) begin @(negedge clk); c++; end
    tests++;
    if (arb_busy !== 1'b0 || c < FRAME) begin
      fails++; $display("FAIL single_idle: arb_busy=%b after %0d cycles, want 0 after >=%0d", arb_busy, c, FRAME);
    end
    tests++;
    if (data_to_send !== 32'hDEAD_BEEF || grant_id !== 2'd2) begin
      fails++; $display("FAIL single_hold: d=%h g=%0d want deadbeef/2", data_to_send, grant_id);
    end
  endtask

  task automatic test_size_edges();
    int first = -1;
    int cyc   = 0;
    set_req(1, 32'h1111_1111, 3'd0);
    set_req(2, 32'h2222_2222, 3'd7);
    push(1, 32'hDEAD_BEEF, 3'd4, 1'b1);
    push(2, 32'h2222_2222, 3'd4, 1'b0);
    req_valid = 4'b0110;
    for (int c = 0; c < 50 && sb.size() != 0; c++) begin
      @(negedge clk);
      cyc++;
      if (|req_ack) begin
        e = sb.pop_front();
        tests++;
        if (req_ack !== 4'(1 << e.id)) begin
          fails++; $display("FAIL size_ack: got %b want id %0d", req_ack, e.id);
        end
        tests++;
        if (e.drop) begin
          first = cyc;
          if (valid_data !== 1'b0 || arb_busy !== 1'b0 || data_to_send !== e.data) begin
            fails++; $display("FAIL size_zero_drop: v=%b arb_busy=%b d=%h want 0/0/%h",
                              valid_data, arb_busy, data_to_send, e.data);
          end
        end else begin
          if ({valid_data, data_to_send, size_of_data, grant_id} !== {1'b1, e.data, e.size, 2'(e.id)}) begin
            fails++; $display("FAIL size_clamp: v=%b d=%h s=%0d g=%0d want 1/%h/%0d/%0d",
                              valid_data, data_to_send, size_of_data, grant_id, e.data, e.size, e.id);
          end
          tests++;
          if (cyc != first + 1) begin
            fails++; $display("FAIL size_rotate_gap: grant at cycle %0d, drop at %0d, want adjacent", cyc, first);
          end
        end
        req_valid[e.id] = 1'b0;
      end
    end
    tests++;
    if (sb.size() != 0) begin
      fails++; $display("FAIL size_timeout: %0d expected acks missing", sb.size());
      sb.delete();
    end
    req_valid = '0;
    for (int c = 0; c < 100 && arb_busy; c++) @(negedge clk);
  endtask

  task automatic test_busy_in_idle();
    int acks = 0;
    set_req(0, 32'h0BAD_CAFE, 3'd2);
    push(0, 32'h0BAD_CAFE, 3'd2, 1'b0);
    force_busy = 1'b1;
    req_valid  = 4'b0001;
    repeat (6) begin
      @(negedge clk);
      if (|req_ack || valid_data || arb_busy) acks++;
    end
    tests++;
    if (acks != 0) begin
      fails++; $display("FAIL busy_idle_hold: %0d cycles with activity, want 0", acks);
    end
    force_busy = 1'b0;
    @(negedge clk);
    e = sb.pop_front();
    tests++;
    if (req_ack !== 4'(1 << e.id) || {valid_data, data_to_send, size_of_data} !== {1'b1, e.data, e.size}) begin
      fails++; $display("FAIL busy_idle_release: ack=%b v=%b d=%h s=%0d want %0d/1/%h/%0d",
                        req_ack, valid_data, data_to_send, size_of_data, e.id, e.data, e.size);
    end
    req_valid = '0;
    for (int c = 0; c < 100 && arb_busy; c++) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    int c = 0;
    int stray = 0;
    set_req(2, 32'h3333_3333, 3'd3);
    req_valid = 4'b0100;
    while (!(|req_ack) && c < 20) begin @(negedge clk); c++; end
    req_valid = '0;
    repeat (3) @(negedge clk);
    tests++;
    if (arb_busy !== 1'b1 || grant_id !== 2'd2) begin
      fails++; $display("FAIL midrst_pre: arb_busy=%b g=%0d want 1/2", arb_busy, grant_id);
    end
    #2 rst = 1'b0;
    #1;
    tests++;
    if ({req_ack, valid_data, data_to_send, size_of_data, grant_id, arb_busy, timeout_err} !== 44'b0) begin
      fails++; $display("FAIL midrst_outputs: ack=%b v=%b d=%h s=%0d g=%0d ab=%b to=%b want all 0",
                        req_ack, valid_data, data_to_send, size_of_data, grant_id, arb_busy, timeout_err);
    end
    @(negedge clk);
    set_req(0, 32'h4444_0000, 3'd1);
    set_req(3, 32'h4444_0003, 3'd1);
    push(0, 32'h4444_0000, 3'd1, 1'b0);
    req_valid = 4'b1001;
    rst = 1'b1;
    @(negedge clk);
    e = sb.pop_front();
    tests++;
    if (req_ack !== 4'(1 << e.id) || grant_id !== 2'(e.id) || data_to_send !== e.data) begin
      fails++; $display("FAIL midrst_first_winner: ack=%b g=%0d d=%h want id %0d d=%h",
                        req_ack, grant_id, data_to_send, e.id, e.data);
    end
    req_valid = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (|req_ack) stray++;
    end
    tests++;
    if (stray != 0 || arb_busy !== 1'b0) begin
      fails++; $display("FAIL midrst_withdraw: %0d stray acks arb_busy=%b want 0/0", stray, arb_busy);
    end
  endtask

`ifdef UART_TX_ARB_WATCHDOG_EN
  task automatic test_watchdog();
    int c = 0;
    sender_en = 1'b0;
    set_req(1, 32'h5555_AAAA, 3'd4);
    push(1, 32'h5555_AAAA, 3'd4, 1'b0);
    req_valid = 4'b0010;
    while (!(|req_ack) && c < 20) begin @(negedge clk); c++; end
    e = sb.pop_front();
    tests++;
    if (req_ack !== 4'(1 << e.id) || data_to_send !== e.data) begin
      fails++; $display("FAIL wd_grant: ack=%b d=%h want id %0d d=%h", req_ack, data_to_send, e.id, e.data);
    end
    set_req(1, 32'h6666_BBBB, 3'd4);
    c = 0;
    do begin @(negedge clk); c++; end while (!timeout_err && c < 40);
    tests++;
    if (timeout_err !== 1'b1 || c != 15 || arb_busy !== 1'b0) begin
      fails++; $display("FAIL wd_expiry: tmo=%b after %0d cycles arb_busy=%b want 1 after 15, 0",
                        timeout_err, c, arb_busy);
    end
    sender_en = 1'b1;
    push(1, 32'h6666_BBBB, 3'd4, 1'b0);
    @(negedge clk);
    e = sb.pop_front();
    tests++;
    if (timeout_err !== 1'b0 || req_ack !== 4'(1 << e.id) || valid_data !== 1'b1 || data_to_send !== e.data) begin
      fails++; $display("FAIL wd_regrant: tmo=%b ack=%b v=%b d=%h want 0/%0d/1/%h",
                        timeout_err, req_ack, valid_data, data_to_send, e.id, e.data);
    end
    req_valid = '0;
    for (int k = 0; k < 100 && arb_busy; k++) @(negedge clk);
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_rotation();
    test_single();
    test_size_edges();
    test_busy_in_idle();
    test_reset_mid_frame();
`ifdef UART_TX_ARB_WATCHDOG_EN
    test_watchdog();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
